// File: rtl/tagged_div_dispatcher.sv
// Issue side of the tagged divider array: tags each accepted word, sends it round-robin to an eligible
// divider and bounds outstanding tags with credits. Define TAGGED_DISPATCH_STATS_EN for issue/stall counters.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif

module tagged_div_dispatcher #(
  parameter int DIV_COUNT    = 16,
  parameter int TAG_SIZE     = `TAG_SIZE,
  parameter int DATA_W       = 96,
  parameter int MAX_INFLIGHT = 32,
  localparam int PTR_W       = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1,
  localparam int INF_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  input  logic [DIV_COUNT-1:0] div_ready_in,
  input  logic [DIV_COUNT-1:0] fifo_overflow_in,
  input  logic                 retire_in,
  output logic [DIV_COUNT-1:0] div_valid_out,
  output logic [TAG_SIZE-1:0]  div_tag_out,
  output logic [DATA_W-1:0]    div_data_out,
  output logic [INF_W-1:0]     inflight_out,
  output logic                 underflow_err_out
`ifdef TAGGED_DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_issued_out,
  output logic [31:0]          stat_stall_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  logic [DIV_COUNT-1:0] eligible_s;
  logic                 found_s;
  logic [PTR_W-1:0]     sel_s;
  logic [PTR_W-1:0]     rr_ptr_r;
  logic [PTR_W-1:0]     rr_nxt_s;
  logic [DIV_COUNT-1:0] onehot_s;
  logic                 credit_ok_s;
  logic                 ready_s;
  logic                 accept_s;

  logic [TAG_SIZE-1:0]  next_tag_r;
  logic [TAG_SIZE-1:0]  tag_inc_s;
  logic [INF_W-1:0]     inflight_r;
  logic [INF_W-1:0]     inflight_nxt_s;
  logic                 underflow_s;
  logic                 underflow_err_r;

  logic [DIV_COUNT-1:0] div_valid_r;
  logic [TAG_SIZE-1:0]  div_tag_r;
  logic [DATA_W-1:0]    div_data_r;

  // Round-robin pick: first eligible lane scanning upward from rr_ptr with wrap.
  always_comb begin
    int idx_v;
    idx_v      = 0;
    eligible_s = div_ready_in & ~fifo_overflow_in;
    sel_s      = rr_ptr_r;
    found_s    = 1'b0;
    for (int k = 0; k < DIV_COUNT; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % DIV_COUNT;
      if (!found_s && eligible_s[idx_v[PTR_W-1:0]]) begin
        sel_s   = idx_v[PTR_W-1:0];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer, one-hot lane and tag successor for the word accepted this cycle.
  always_comb begin
    if (sel_s == PTR_W'(DIV_COUNT - 1)) begin
      rr_nxt_s = {PTR_W{1'b0}};
    end else begin
      rr_nxt_s = sel_s + PTR_W'(1);
    end
    onehot_s = {{(DIV_COUNT-1){1'b0}}, 1'b1} << sel_s;
    // Tag 0 is reserved, so the counter wraps from all-ones back to 1.
    if (next_tag_r == {TAG_SIZE{1'b1}}) begin
      tag_inc_s = TAG_SIZE'(1);
    end else begin
      tag_inc_s = next_tag_r + TAG_SIZE'(1);
    end
  end

  // Credit state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next credit state tracks the updated inflight count only.
  always_comb begin
    if (inflight_nxt_s == {INF_W{1'b0}}) begin
      state_nxt_s = ST_IDLE;
    end else if (inflight_nxt_s == INF_W'(MAX_INFLIGHT)) begin
      state_nxt_s = ST_FULL;
    end else begin
      state_nxt_s = ST_RUN;
    end
  end

  // Credit availability decoded from the credit state.
  always_comb begin
    case (state_r)
      ST_IDLE: credit_ok_s = 1'b1;
      ST_RUN:  credit_ok_s = 1'b1;
      ST_FULL: credit_ok_s = 1'b0;
      default: credit_ok_s = 1'b0;
    endcase
  end

  assign ready_s  = ~reset & found_s & credit_ok_s;
  assign accept_s = in_valid & ready_s;

  // Inflight update; a simultaneous accept and retire cancel out.
  always_comb begin
    inflight_nxt_s = inflight_r;
    underflow_s    = 1'b0;
    case ({accept_s, retire_in})
      2'b10: inflight_nxt_s = inflight_r + INF_W'(1);
      2'b01: begin
        if (inflight_r == {INF_W{1'b0}}) begin
          underflow_s = 1'b1;
        end else begin
          inflight_nxt_s = inflight_r - INF_W'(1);
        end
      end
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Issue registers, tag/pointer state, credit counter and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_valid_r     <= {DIV_COUNT{1'b0}};
      div_tag_r       <= {TAG_SIZE{1'b0}};
      div_data_r      <= {DATA_W{1'b0}};
      next_tag_r      <= TAG_SIZE'(1);
      rr_ptr_r        <= {PTR_W{1'b0}};
      inflight_r      <= {INF_W{1'b0}};
      underflow_err_r <= 1'b0;
    end else begin
      inflight_r      <= inflight_nxt_s;
      underflow_err_r <= underflow_err_r | underflow_s;
      if (accept_s) begin
        div_valid_r <= onehot_s;
        div_tag_r   <= next_tag_r;
        div_data_r  <= in_data;
        next_tag_r  <= tag_inc_s;
        rr_ptr_r    <= rr_nxt_s;
      end else begin
        div_valid_r <= {DIV_COUNT{1'b0}};
      end
    end
  end

  assign in_ready          = ready_s;
  assign div_valid_out     = div_valid_r;
  assign div_tag_out       = div_tag_r;
  assign div_data_out      = div_data_r;
  assign inflight_out      = inflight_r;
  assign underflow_err_out = underflow_err_r;

`ifdef TAGGED_DISPATCH_STATS_EN
  logic [31:0] stat_issued_r;
  logic [31:0] stat_stall_r;

  // Saturating issue and stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued_r <= 32'd0;
      stat_stall_r  <= 32'd0;
    end else begin
      if (accept_s && (stat_issued_r != 32'hFFFF_FFFF)) begin
        stat_issued_r <= stat_issued_r + 32'd1;
      end else begin
        stat_issued_r <= stat_issued_r;
      end
      if (in_valid && !ready_s && (stat_stall_r != 32'hFFFF_FFFF)) begin
        stat_stall_r <= stat_stall_r + 32'd1;
      end else begin
        stat_stall_r <= stat_stall_r;
      end
    end
  end

  assign stat_issued_out = stat_issued_r;
  assign stat_stall_out  = stat_stall_r;
`endif

endmodule

// File: tb/tb_tagged_div_dispatcher.sv
// Self-checking bench for tagged_div_dispatcher: scenario tasks with inline checks plus a
// scoreboard fed by a reference model, run with TAG_SIZE=3 and MAX_INFLIGHT=4.
`timescale 1ns/1ps

module tb_tagged_div_dispatcher;

  localparam int NDIV = 16;
  localparam int TW   = 3;
  localparam int DW   = 96;
  localparam int MAXI = 4;
  localparam int IW   = 3;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [NDIV-1:0] div_ready_in;
  logic [NDIV-1:0] fifo_overflow_in;
  logic            retire_in;
  logic [NDIV-1:0] div_valid_out;
  logic [TW-1:0]   div_tag_out;
  logic [DW-1:0]   div_data_out;
  logic [IW-1:0]   inflight_out;
  logic            underflow_err_out;
`ifdef TAGGED_DISPATCH_STATS_EN
  logic [31:0]     stat_issued_out;
  logic [31:0]     stat_stall_out;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic mon_en = 1'b0;

  tagged_div_dispatcher #(
    .DIV_COUNT(NDIV), .TAG_SIZE(TW), .DATA_W(DW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .div_ready_in(div_ready_in), .fifo_overflow_in(fifo_overflow_in), .retire_in(retire_in),
    .div_valid_out(div_valid_out), .div_tag_out(div_tag_out), .div_data_out(div_data_out),
    .inflight_out(inflight_out), .underflow_err_out(underflow_err_out)
`ifdef TAGGED_DISPATCH_STATS_EN
    , .stat_issued_out(stat_issued_out), .stat_stall_out(stat_stall_out)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic [NDIV-1:0] lanes;
    logic [TW-1:0]   tag;
    logic [DW-1:0]   data;
  } exp_t;

  exp_t sb_q[$];

  int   m_rr   = 0;
  int   m_tag  = 1;
  int   m_inf  = 0;
  logic m_err  = 1'b0;
  int   m_sel;
  logic m_ready;
  logic m_acc;

  function automatic int pick(input logic [NDIV-1:0] el, input int rr);
    for (int k = 0; k < NDIV; k++) begin
      if (el[(rr + k) % NDIV]) return (rr + k) % NDIV;
    end
    return -1;
  endfunction

  always_comb begin
    m_sel   = pick(div_ready_in & ~fifo_overflow_in, m_rr);
    m_ready = !reset && (m_sel >= 0) && (m_inf < MAXI);
    m_acc   = in_valid && m_ready;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_rr  <= 0;
      m_tag <= 1;
      m_inf <= 0;
      m_err <= 1'b0;
    end else begin
      if (m_acc) begin
        sb_q.push_back(exp_t'{lanes: NDIV'(32'd1 << m_sel), tag: TW'(m_tag), data: in_data});
        m_rr  <= (m_sel + 1) % NDIV;
        m_tag <= (m_tag == 7) ? 1 : m_tag + 1;
      end
      if (m_acc && !retire_in) begin
        m_inf <= m_inf + 1;
      end else if (!m_acc && retire_in) begin
        if (m_inf == 0) m_err <= 1'b1;
        else m_inf <= m_inf - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if (in_ready !== m_ready) begin
        n_err++;
        $display("FAIL sb_in_ready t=%0t got=%b exp=%b", $time, in_ready, m_ready);
      end
      n_vec++;
      if (inflight_out !== IW'(m_inf)) begin
        n_err++;
        $display("FAIL sb_inflight t=%0t got=%0d exp=%0d", $time, inflight_out, m_inf);
      end
      n_vec++;
      if (underflow_err_out !== m_err) begin
        n_err++;
        $display("FAIL sb_underflow t=%0t got=%b exp=%b", $time, underflow_err_out, m_err);
      end
      if (sb_q.size() != 0) begin
        n_vec++;
        if ({div_valid_out, div_tag_out, div_data_out} !== {sb_q[0].lanes, sb_q[0].tag, sb_q[0].data}) begin
          n_err++;
          $display("FAIL sb_issue t=%0t got lanes=%h tag=%0d data=%h exp lanes=%h tag=%0d data=%h",
                   $time, div_valid_out, div_tag_out, div_data_out, sb_q[0].lanes, sb_q[0].tag, sb_q[0].data);
        end
        n_vec++;
        if (div_tag_out === {TW{1'b0}}) begin
          n_err++;
          $display("FAIL sb_tag_zero t=%0t got=%0d exp=nonzero", $time, div_tag_out);
        end
        sb_q.delete(0);
      end else begin
        n_vec++;
        if (div_valid_out !== {NDIV{1'b0}}) begin
          n_err++;
          $display("FAIL sb_idle t=%0t got lanes=%h exp=0", $time, div_valid_out);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_data();
    in_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    in_valid         = 1'b0;
    retire_in        = 1'b0;
    div_ready_in     = {NDIV{1'b1}};
    fifo_overflow_in = {NDIV{1'b0}};
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid  = 1'b0;
    retire_in = 1'b1;
    repeat (n) tick();
    retire_in = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset            = 1'b1;
    in_valid         = 1'b1;
    in_data          = {DW{1'b1}};
    retire_in        = 1'b0;
    div_ready_in     = {NDIV{1'b1}};
    fifo_overflow_in = {NDIV{1'b0}};
    tick();
    tick();
    mon_en = 1'b1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_ready got=%b exp=0", in_ready);
    end
    n_vec++;
    if ({div_valid_out, div_tag_out, div_data_out, inflight_out, underflow_err_out} !== {(NDIV+TW+DW+IW+1){1'b0}}) begin
      n_err++;
      $display("FAIL reset_outputs got lanes=%h tag=%0d data=%h inf=%0d err=%b exp all zero",
               div_valid_out, div_tag_out, div_data_out, inflight_out, underflow_err_out);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      new_data();
      tick();
      n_vec++;
      if (div_valid_out !== NDIV'(32'd1 << i) || div_tag_out !== TW'(i + 1)) begin
        n_err++;
        $display("FAIL seq_issue%0d got lanes=%h tag=%0d exp lanes=%h tag=%0d",
                 i, div_valid_out, div_tag_out, NDIV'(32'd1 << i), i + 1);
      end
    end
    drain(4);
  endtask

  task automatic test_skip_lane();
    do_reset();
    in_valid = 1'b1;
    new_data();
    div_ready_in = 16'hFFFE;
    tick();
    n_vec++;
    if (div_valid_out !== 16'h0002) begin
      n_err++; $display("FAIL skip_busy got=%h exp=0002", div_valid_out);
    end
    div_ready_in     = 16'hFFFF;
    fifo_overflow_in = 16'h0004;
    new_data();
    tick();
    n_vec++;
    if (div_valid_out !== 16'h0008) begin
      n_err++; $display("FAIL skip_overflow got=%h exp=0008", div_valid_out);
    end
    fifo_overflow_in = 16'hFFF0;
    new_data();
    tick();
    n_vec++;
    if (div_valid_out !== 16'h0001) begin
      n_err++; $display("FAIL skip_wrap got=%h exp=0001", div_valid_out);
    end
    div_ready_in     = 16'h0000;
    fifo_overflow_in = 16'h0000;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL skip_none_ready got=%b exp=0", in_ready);
    end
    tick();
    div_ready_in     = 16'hFFFF;
    fifo_overflow_in = 16'h0002;
    in_valid         = 1'b0;
    tick();
    fifo_overflow_in = 16'h0000;
    in_valid         = 1'b1;
    new_data();
    tick();
    n_vec++;
    if (div_valid_out !== 16'h0002) begin
      n_err++; $display("FAIL skip_rejoin got=%h exp=0002", div_valid_out);
    end
    drain(4);
  endtask

  task automatic test_credit_limit();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      new_data();
      tick();
    end
    n_vec++;
    if (in_ready !== 1'b0 || inflight_out !== 3'd4 || div_valid_out !== 16'h0000) begin
      n_err++;
      $display("FAIL credit_full got ready=%b inf=%0d lanes=%h exp ready=0 inf=4 lanes=0000",
               in_ready, inflight_out, div_valid_out);
    end
    retire_in = 1'b1;
    tick();
    retire_in = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || inflight_out !== 3'd3) begin
      n_err++; $display("FAIL credit_retire got ready=%b inf=%0d exp ready=1 inf=3", in_ready, inflight_out);
    end
    tick();
    n_vec++;
    if (div_valid_out !== 16'h0010 || div_tag_out !== 3'd5 || inflight_out !== 3'd4) begin
      n_err++;
      $display("FAIL credit_fifth got lanes=%h tag=%0d inf=%0d exp lanes=0010 tag=5 inf=4",
               div_valid_out, div_tag_out, inflight_out);
    end
    drain(4);
  endtask

  task automatic test_tag_wrap();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      retire_in = (i > 0);
      new_data();
      tick();
      n_vec++;
      if (div_tag_out !== TW'((i % 7) + 1) || div_valid_out !== NDIV'(32'd1 << i)) begin
        n_err++;
        $display("FAIL wrap_tag%0d got tag=%0d lanes=%h exp tag=%0d lanes=%h",
                 i, div_tag_out, div_valid_out, (i % 7) + 1, NDIV'(32'd1 << i));
      end
    end
    drain(1);
    n_vec++;
    if (inflight_out !== 3'd0 || underflow_err_out !== 1'b0) begin
      n_err++; $display("FAIL wrap_drain got inf=%0d err=%b exp inf=0 err=0", inflight_out, underflow_err_out);
    end
  endtask

  task automatic test_accept_retire();
    do_reset();
    in_valid = 1'b1;
    new_data();
    tick();
    new_data();
    tick();
    retire_in = 1'b1;
    new_data();
    tick();
    n_vec++;
    if (inflight_out !== 3'd2 || div_valid_out !== 16'h0004 || div_tag_out !== 3'd3) begin
      n_err++;
      $display("FAIL acc_ret got inf=%0d lanes=%h tag=%0d exp inf=2 lanes=0004 tag=3",
               inflight_out, div_valid_out, div_tag_out);
    end
    drain(2);
    n_vec++;
    if (inflight_out !== 3'd0 || underflow_err_out !== 1'b0) begin
      n_err++; $display("FAIL acc_ret_drain got inf=%0d err=%b exp inf=0 err=0", inflight_out, underflow_err_out);
    end
    drain(1);
    tick();
    n_vec++;
    if (inflight_out !== 3'd0 || underflow_err_out !== 1'b1) begin
      n_err++; $display("FAIL underflow_sticky got inf=%0d err=%b exp inf=0 err=1", inflight_out, underflow_err_out);
    end
    do_reset();
    n_vec++;
    if (underflow_err_out !== 1'b0) begin
      n_err++; $display("FAIL underflow_clear got=%b exp=0", underflow_err_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    new_data();
    tick();
    new_data();
    tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if (div_valid_out !== 16'h0000 || inflight_out !== 3'd0) begin
      n_err++; $display("FAIL midreset got lanes=%h inf=%0d exp lanes=0000 inf=0", div_valid_out, inflight_out);
    end
    reset = 1'b0;
    new_data();
    tick();
    n_vec++;
    if (div_valid_out !== 16'h0001 || div_tag_out !== 3'd1) begin
      n_err++; $display("FAIL midreset_first got lanes=%h tag=%0d exp lanes=0001 tag=1", div_valid_out, div_tag_out);
    end
    drain(1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      in_valid         = ($urandom_range(0, 3) != 0);
      div_ready_in     = NDIV'($urandom | $urandom);
      fifo_overflow_in = NDIV'($urandom & $urandom & $urandom);
      retire_in        = ($urandom_range(0, 2) == 0);
      new_data();
      tick();
    end
    in_valid  = 1'b0;
    retire_in = 1'b0;
    tick();
    tick();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL b2b_pending got=%0d exp=0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_skip_lane();
    test_credit_limit();
    test_tag_wrap();
    test_accept_retire();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
